// File: rtl/bsg_link_downstream_in_if.sv
// ---------------------------------------------------------------------------
// bsg_link_downstream_in_if
//   Bundles the link-side receive signals and the core-side FIFO handshake of
//   bsg_link_downstream_in.
//
//   Handshake semantics:
//     link side : io_valid_in marks the P beat of a two-beat word frame; the
//                 following cycle is always the N beat. No backpressure exists
//                 on the link -- flow control is the io_token_out credit toggle.
//     core side : core_valid_out is high whenever the FIFO holds an entry and
//                 core_data_out shows that head entry. core_yumi_in is a
//                 same-cycle consume: when core_valid_out & core_yumi_in at a
//                 rising clk edge, the head is removed. core_yumi_in is ignored
//                 while core_valid_out is low.
//
//   Modports:
//     master : transmitter/core environment (drives inputs of the receiver)
//     slave  : the receiver block itself
// ---------------------------------------------------------------------------
interface bsg_link_downstream_in_if;
  logic        io_valid_in;
  logic [7:0]  io_data_ch0_in;
  logic [7:0]  io_data_ch1_in;
  logic [63:0] core_data_out;
  logic        core_valid_out;
  logic        core_yumi_in;
  logic        io_token_out;

  modport master (
    output io_valid_in, io_data_ch0_in, io_data_ch1_in, core_yumi_in,
    input  core_data_out, core_valid_out, io_token_out
  );

  modport slave (
    input  io_valid_in, io_data_ch0_in, io_data_ch1_in, core_yumi_in,
    output core_data_out, core_valid_out, io_token_out
  );
endinterface

// File: rtl/bsg_link_downstream_in.sv
// ---------------------------------------------------------------------------
// bsg_link_downstream_in
//   Receive side of the DDR link. Each 32-bit word arrives as a P beat
//   (ch0 -> [7:0], ch1 -> [23:16]) followed by an N beat (ch0 -> [15:8],
//   ch1 -> [31:24]). Two consecutive words form one 64-bit entry {word1,word0}
//   which is queued in a FIFO toward the core. Every 2^LG_TOKEN_DECIMATION
//   dequeues toggle io_token_out to return credit to the transmitter.
//
// Ports:
//   clk, rst     : single clock; synchronous active-high reset
//   link         : bsg_link_downstream_in_if.slave (io_* and core_* signals)
//   phase_state  : debug view of the phase FSM (0 = P_IDLE, 1 = N_BEAT)
//   overflow_o   : sticky, an entry was dropped because the FIFO was full
//   err_cnt_o    : [7:0] saturating count of framing errors and dropped
//                  entries; present only when BSG_LINK_DOWNSTREAM_ERR_CNT_EN
//                  is defined
//
// Parameters:
//   FIFO_DEPTH          : 64-bit entries buffered (power of 2, >= 2)
//   LG_TOKEN_DECIMATION : log2 of dequeues per io_token_out toggle (>= 1)
// ---------------------------------------------------------------------------
module bsg_link_downstream_in #(
  parameter int FIFO_DEPTH          = 32,
  parameter int LG_TOKEN_DECIMATION = 1
) (
  input  logic clk,
  input  logic rst,
  bsg_link_downstream_in_if.slave link,
  output logic phase_state,
  output logic overflow_o
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
  ,output logic [7:0] err_cnt_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {P_IDLE = 1'b0, N_BEAT = 1'b1} phase_e;

  phase_e      phase_q, phase_d;
  logic        capture_p;
  logic        complete;
  logic [7:0]  p_ch0_q, p_ch1_q;
  logic [31:0] cur_word;
  logic [31:0] low_word_q;
  logic        word_idx_q;

  logic [63:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, push, pop, do_write, drop;

  logic [LG_TOKEN_DECIMATION-1:0] tok_cnt_q;
  logic        token_q;
  logic        overflow_q;

  // ---------------- phase FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) phase_q <= P_IDLE;
    else     phase_q <= phase_d;
  end

  // The N beat is taken unconditionally: a valid seen there is a framing
  // error, but its bytes are still used as the N half of the word.
  always_comb begin
    phase_d   = phase_q;
    capture_p = 1'b0;
    complete  = 1'b0;
    unique case (phase_q)
      P_IDLE: begin
        if (link.io_valid_in) begin
          capture_p = 1'b1;
          phase_d   = N_BEAT;
        end
      end
      N_BEAT: begin
        complete = 1'b1;
        phase_d  = P_IDLE;
      end
    endcase
  end

  assign phase_state = phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_ch0_q <= 8'h00;
      p_ch1_q <= 8'h00;
    end else if (capture_p) begin
      p_ch0_q <= link.io_data_ch0_in;
      p_ch1_q <= link.io_data_ch1_in;
    end
  end

  // Word completes combinationally during the N beat so the entry is written
  // at the end of that cycle and visible the cycle after.
  assign cur_word = {link.io_data_ch1_in, p_ch1_q, link.io_data_ch0_in, p_ch0_q};

  // ---------------- word pairing ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx_q <= 1'b0;
      low_word_q <= 32'h0;
    end else if (complete) begin
      word_idx_q <= ~word_idx_q;
      if (!word_idx_q) low_word_q <= cur_word;
    end
  end

  assign push = complete & word_idx_q;

  // ---------------- FIFO ----------------
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop      = ~empty & link.core_yumi_in;
  // A pop in the same cycle frees the slot the push lands in, even when full.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q[AW-1:0]] <= {cur_word, low_word_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign link.core_valid_out = ~empty;
  assign link.core_data_out  = empty ? 64'h0 : mem[rd_ptr_q[AW-1:0]];

  // ---------------- credit return ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tok_cnt_q <= '0;
      token_q   <= 1'b0;
    end else if (pop) begin
      tok_cnt_q <= tok_cnt_q + 1'b1;
      if (&tok_cnt_q) token_q <= ~token_q;
    end
  end

  assign link.io_token_out = token_q;

  // ---------------- overflow ----------------
  always_ff @(posedge clk) begin
    if (rst)       overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

  assign overflow_o = overflow_q;

`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
  logic       framing_err;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic [7:0] err_cnt_q;

  // Both events can coincide (bad N beat that also completes a dropped entry).
  assign framing_err = complete & link.io_valid_in;
  assign err_inc     = {1'b0, framing_err} + {1'b0, drop};
  assign err_sum     = {1'b0, err_cnt_q} + {7'b0, err_inc};

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_link_downstream_in.sv
// ---------------------------------------------------------------------------
// tb_bsg_link_downstream_in
//   Bench for bsg_link_downstream_in: a vector table for the single-entry,
//   idle-gap and first credit checks, then hand-written sequences for credit
//   return, full/overflow, framing error and reset mid-assembly. Entries are
//   pushed to exp_q when the frames are sent and compared on every dequeue.
// ---------------------------------------------------------------------------
module tb_bsg_link_downstream_in;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bsg_link_downstream_in_if link();
  logic phase_state;
  logic overflow_o;
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
  logic [7:0] err_cnt_o;
`endif

  bsg_link_downstream_in #(.FIFO_DEPTH(32), .LG_TOKEN_DECIMATION(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .link        (link),
    .phase_state (phase_state),
    .overflow_o  (overflow_o)
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
    ,.err_cnt_o  (err_cnt_o)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic beat(input logic v, input logic [7:0] c0, input logic [7:0] c1, input logic y);
    link.io_valid_in    = v;
    link.io_data_ch0_in = c0;
    link.io_data_ch1_in = c1;
    link.core_yumi_in   = y;
    @(posedge clk);
    #1;
    link.io_valid_in  = 1'b0;
    link.core_yumi_in = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic v_on_n, input logic y_on_n);
    beat(1'b1, w[7:0], w[23:16], 1'b0);
    beat(v_on_n, w[15:8], w[31:24], y_on_n);
  endtask

  task automatic send_pair(input logic [31:0] w0, input logic [31:0] w1,
                           input logic expect_push, input logic y_last);
    send_word(w0, 1'b0, 1'b0);
    if (expect_push) exp_q.push_back({w1, w0});
    send_word(w1, 1'b0, y_last);
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    link.io_valid_in    = 1'b0;
    link.io_data_ch0_in = 8'h00;
    link.io_data_ch1_in = 8'h00;
    link.core_yumi_in   = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 8'h00, 8'h00, 1'b1);
  endtask

  // ---------------- scoreboard: compare on every dequeue ----------------
  always @(negedge clk) begin
    if (!rst && link.core_valid_out && link.core_yumi_in) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got %h expected no entry", link.core_data_out);
      end else begin
        chk("pop_data", link.core_data_out, exp_q.pop_front());
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        v;
    logic [7:0]  c0;
    logic [7:0]  c1;
    logic        y;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic        exp_token;
  } vec_t;

  localparam logic [63:0] E1 = 64'h8877665544332211;
  localparam logic [63:0] E2 = 64'h0807060504030201;

  vec_t tbl[16];

  initial begin
    logic [31:0] wa, wb;

    // single entry, then a second entry with five idle P cycles in between
    tbl[0]  = '{1'b1, 8'h11, 8'h33, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[1]  = '{1'b0, 8'h22, 8'h44, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[2]  = '{1'b1, 8'h55, 8'h77, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[3]  = '{1'b0, 8'h66, 8'h88, 1'b0, 1'b1, E1,    1'b0};
    tbl[4]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0, 1'b0};
    tbl[5]  = '{1'b1, 8'h01, 8'h03, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[6]  = '{1'b0, 8'h02, 8'h04, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[7]  = '{1'b0, 8'hEE, 8'hDD, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[8]  = '{1'b0, 8'hEE, 8'hDD, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[9]  = '{1'b0, 8'hEE, 8'hDD, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[10] = '{1'b0, 8'hEE, 8'hDD, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[11] = '{1'b0, 8'hEE, 8'hDD, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[12] = '{1'b1, 8'h05, 8'h07, 1'b0, 1'b0, 64'h0, 1'b0};
    tbl[13] = '{1'b0, 8'h06, 8'h08, 1'b0, 1'b1, E2,    1'b0};
    tbl[14] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 64'h0, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 64'h0, 1'b1};

    // ---------------- reset state ----------------
    do_reset();
    chk("reset_valid",    link.core_valid_out, 1'b0);
    chk("reset_data",     link.core_data_out,  64'h0);
    chk("reset_token",    link.io_token_out,   1'b0);
    chk("reset_overflow", overflow_o,          1'b0);
    chk("reset_phase",    phase_state,         1'b0);
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
    chk("reset_err_cnt",  err_cnt_o,           8'h00);
`endif

    // ---------------- table: single entry + idle gaps ----------------
    exp_q.push_back(E1);
    exp_q.push_back(E2);
    for (int i = 0; i < 16; i++) begin
      beat(tbl[i].v, tbl[i].c0, tbl[i].c1, tbl[i].y);
      chk($sformatf("tbl%0d_valid", i), link.core_valid_out, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_data", i),  link.core_data_out,  tbl[i].exp_data);
      chk($sformatf("tbl%0d_token", i), link.io_token_out,   tbl[i].exp_token);
    end
    chk("tbl_sb_empty", exp_q.size(), 0);

    // ---------------- credit return ----------------
    do_reset();
    for (int i = 0; i < 4; i++) send_pair($urandom(), $urandom(), 1'b1, 1'b0);
    chk("credit_valid", link.core_valid_out, 1'b1);
    for (int i = 0; i < 4; i++) begin
      beat(1'b0, 8'h00, 8'h00, 1'b1);
      chk($sformatf("credit_token_after_pop%0d", i + 1), link.io_token_out,
          (i == 1 || i == 2) ? 1'b1 : 1'b0);
    end
    chk("credit_empty", link.core_valid_out, 1'b0);
    chk("credit_sb_empty", exp_q.size(), 0);

    // ---------------- full then overflow ----------------
    do_reset();
    for (int i = 0; i < 32; i++) send_pair($urandom(), $urandom(), 1'b1, 1'b0);
    chk("full_valid", link.core_valid_out, 1'b1);
    chk("full_no_overflow", overflow_o, 1'b0);
    send_pair($urandom(), $urandom(), 1'b0, 1'b0);
    chk("ovf_set", overflow_o, 1'b1);
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
    chk("ovf_err_cnt", err_cnt_o, 8'h01);
`endif
    chk("ovf_head", link.core_data_out, exp_q[0]);
    drain(32);
    chk("ovf_drained", link.core_valid_out, 1'b0);
    chk("ovf_sticky", overflow_o, 1'b1);
    chk("ovf_sb_empty", exp_q.size(), 0);

    // ---------------- full with pop on the push cycle ----------------
    do_reset();
    for (int i = 0; i < 32; i++) send_pair($urandom(), $urandom(), 1'b1, 1'b0);
    send_pair($urandom(), $urandom(), 1'b1, 1'b1);
    chk("fullpop_no_overflow", overflow_o, 1'b0);
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
    chk("fullpop_err_cnt", err_cnt_o, 8'h00);
`endif
    drain(32);
    chk("fullpop_drained", link.core_valid_out, 1'b0);
    chk("fullpop_sb_empty", exp_q.size(), 0);

    // ---------------- framing error ----------------
    do_reset();
    wa = 32'hA4A3A2A1;
    wb = 32'hB4B3B2B1;
    send_word(wa, 1'b1, 1'b0);
    chk("frm_phase_back_to_p", phase_state, 1'b0);
`ifdef BSG_LINK_DOWNSTREAM_ERR_CNT_EN
    chk("frm_err_cnt", err_cnt_o, 8'h01);
`endif
    exp_q.push_back({wb, wa});
    send_word(wb, 1'b0, 1'b0);
    chk("frm_valid", link.core_valid_out, 1'b1);
    beat(1'b0, 8'h00, 8'h00, 1'b1);
    chk("frm_drained", link.core_valid_out, 1'b0);
    chk("frm_sb_empty", exp_q.size(), 0);

    // ---------------- reset mid-frame and mid-assembly ----------------
    do_reset();
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    beat(1'b1, 8'h5A, 8'hA5, 1'b0);
    chk("midrst_phase_n", phase_state, 1'b1);
    do_reset();
    chk("midrst_phase_p", phase_state, 1'b0);
    chk("midrst_valid0", link.core_valid_out, 1'b0);
    send_pair(32'h13579BDF, 32'h2468ACE0, 1'b1, 1'b0);
    chk("midrst_valid", link.core_valid_out, 1'b1);
    chk("midrst_data", link.core_data_out, 64'h2468ACE013579BDF);
    beat(1'b0, 8'h00, 8'h00, 1'b1);
    chk("midrst_one_entry", link.core_valid_out, 1'b0);
    chk("midrst_sb_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
